// File: rtl/priority_code_decoder_if.sv
// Code/grant channel between the priority encoder, the priority code decoder and its consumer.
// The decoder takes the slave modport; the upstream/consumer environment takes master.
interface priority_code_decoder_if;
   logic [3:0]  code_in;
   logic        code_valid;
   logic        code_ready;
   logic [15:0] grant;
   logic [3:0]  grant_code;
   logic        grant_valid;
   logic        grant_ack;

   modport master (
      output code_in, code_valid, grant_ack,
      input  code_ready, grant, grant_code, grant_valid
   );

   modport slave (
      input  code_in, code_valid, grant_ack,
      output code_ready, grant, grant_code, grant_valid
   );
endinterface

// File: rtl/priority_code_decoder.sv
// Turns one 4-bit priority code per handshake into a held one-hot grant, with a timeout FSM.
// Define DEC_STATS_EN to add saturating stat_grants / stat_timeouts counters.
module priority_code_decoder #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TMR_W          = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    En,
   priority_code_decoder_if.slave  bus,
   input  logic                    err_clr,
   output logic                    timeout_err,
   output logic                    busy
`ifdef DEC_STATS_EN
   ,
   output logic [15:0]             stat_grants,
   output logic [15:0]             stat_timeouts
`endif
);

   typedef enum logic [1:0] {IDLE, GRANT, EXPIRE} state_t;

   localparam logic [TMR_W-1:0] TMR_LAST =
      TMR_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   state_t           state, state_nxt;
   logic [TMR_W-1:0] timer, timer_nxt;
   logic             accept;
   logic             expire;

   function automatic logic [15:0] decode(input logic [3:0] c);
      logic [3:0] idx;
      case (c)
         4'b0000: idx = 4'd15;
         4'b0010: idx = 4'd14;
         4'b0100: idx = 4'd13;
         4'b0110: idx = 4'd12;
         4'b1000: idx = 4'd11;
         4'b1010: idx = 4'd10;
         4'b1100: idx = 4'd9;
         4'b1110: idx = 4'd8;
         4'b1111: idx = 4'd7;
         4'b1101: idx = 4'd6;
         4'b1011: idx = 4'd5;
         4'b1001: idx = 4'd4;
         4'b0111: idx = 4'd3;
         4'b0101: idx = 4'd2;
         4'b0011: idx = 4'd1;
         default: idx = 4'd0;
      endcase
      return 16'h0001 << idx;
   endfunction

   assign bus.code_ready = (state == IDLE) && En;
   assign busy           = (state != IDLE);

   // NOTE: every output of this block gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      accept    = 1'b0;
      expire    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.code_valid && bus.code_ready) begin
               state_nxt = GRANT;
               timer_nxt = '0;
               accept    = 1'b1;
            end
         end
         GRANT: begin
            // Disable beats ack, ack beats expiry.
            if (!En || bus.grant_ack) begin
               state_nxt = IDLE;
            end else if ((TIMEOUT_CYCLES != 0) && (timer == TMR_LAST)) begin
               state_nxt = EXPIRE;
               expire    = 1'b1;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer           <= '0;
         bus.grant       <= '0;
         bus.grant_code  <= '0;
         bus.grant_valid <= 1'b0;
         timeout_err     <= 1'b0;
      end else begin
         timer           <= timer_nxt;
         bus.grant_valid <= (state_nxt == GRANT);
         if (accept) begin
            bus.grant      <= decode(bus.code_in);
            bus.grant_code <= bus.code_in;
         end else if (state_nxt != GRANT) begin
            bus.grant <= '0;
         end
         if (expire)       timeout_err <= 1'b1;
         else if (err_clr) timeout_err <= 1'b0;
      end
   end

`ifdef DEC_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_grants   <= '0;
         stat_timeouts <= '0;
      end else if (err_clr) begin
         stat_grants   <= '0;
         stat_timeouts <= '0;
      end else begin
         if (accept && (stat_grants != 16'hFFFF))   stat_grants   <= stat_grants + 16'd1;
         if (expire && (stat_timeouts != 16'hFFFF)) stat_timeouts <= stat_timeouts + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_priority_code_decoder.sv
// Self-checking bench for priority_code_decoder (TIMEOUT_CYCLES=4): code table sweep,
// directed timeout/enable/reset sequences and randomized transactions against a duration model.
module tb_priority_code_decoder;

   localparam int T = 4;

   logic clk = 1'b0;
   logic rst;
   logic En;
   logic err_clr;
   logic timeout_err;
   logic busy;
`ifdef DEC_STATS_EN
   logic [15:0] stat_grants;
   logic [15:0] stat_timeouts;
`endif

   priority_code_decoder_if bus();

   priority_code_decoder #(.TIMEOUT_CYCLES(T), .TMR_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .En          (En),
      .bus         (bus),
      .err_clr     (err_clr),
      .timeout_err (timeout_err),
      .busy        (busy)
`ifdef DEC_STATS_EN
      ,
      .stat_grants   (stat_grants),
      .stat_timeouts (stat_timeouts)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit err_m;
   int grants_m;
   int timeouts_m;

   typedef struct {
      logic [3:0]  code;
      logic [15:0] exp_grant;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference mapping: even codes count down from bit 15, odd codes count up from bit 0.
   function automatic logic [15:0] ref_grant(input logic [3:0] c);
      int bitpos;
      bitpos = c[0] ? (int'(c) / 2) : (15 - int'(c) / 2);
      return 16'(1) << bitpos;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_stats();
`ifdef DEC_STATS_EN
      check("stat_grants", 32'(stat_grants), 32'(grants_m));
      check("stat_timeouts", 32'(stat_timeouts), 32'(timeouts_m));
`endif
   endtask

   // One transaction from IDLE: accept code c, ack on GRANT cycle a (a >= T means no ack),
   // optional err_clr on the accept cycle and/or on GRANT cycle clr_k.
   task automatic run_txn(input logic [3:0] c, input logic [15:0] exp_g, input int a,
                          input bit clr_idle, input int clr_k);
      bit expires;
      int hold;
      expires = (a >= T);
      hold    = expires ? T : a + 1;
      bus.code_in    = c;
      bus.code_valid = 1'b1;
      bus.grant_ack  = 1'($urandom_range(0, 1));
      err_clr        = clr_idle;
      #1 check("code_ready_idle", 32'(bus.code_ready), 32'd1);
      @(posedge clk); #1;
      bus.code_valid = 1'b0;
      bus.grant_ack  = 1'b0;
      err_clr        = 1'b0;
      if (clr_idle) begin
         err_m = 1'b0; grants_m = 0; timeouts_m = 0;
      end else begin
         grants_m++;
      end
      for (int k = 0; k < hold; k++) begin
         check("grant", 32'(bus.grant), 32'(exp_g));
         check("grant_valid", 32'(bus.grant_valid), 32'd1);
         check("grant_code", 32'(bus.grant_code), 32'(c));
         check("timeout_err_hold", 32'(timeout_err), 32'(err_m));
         check("code_ready_busy", 32'(bus.code_ready), 32'd0);
         bus.grant_ack = (k == a);
         err_clr       = (k == clr_k);
         tick();
         bus.grant_ack = 1'b0;
         err_clr       = 1'b0;
         if (k == clr_k) begin
            err_m = 1'b0; grants_m = 0; timeouts_m = 0;
         end
         if (expires && k == hold - 1) begin
            err_m = 1'b1;
            if (k != clr_k) timeouts_m++;
         end
      end
      if (expires) begin
         check("expire_grant", 32'(bus.grant), 32'd0);
         check("expire_valid", 32'(bus.grant_valid), 32'd0);
         check("expire_err", 32'(timeout_err), 32'(err_m));
         check("expire_busy", 32'(busy), 32'd1);
         tick();
      end
      check("idle_grant", 32'(bus.grant), 32'd0);
      check("idle_valid", 32'(bus.grant_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_err", 32'(timeout_err), 32'(err_m));
      check_stats();
   endtask

   vec_t vecs[16];

   initial begin
      vecs[0]  = '{4'b0000, 16'h8000}; vecs[1]  = '{4'b0010, 16'h4000};
      vecs[2]  = '{4'b0100, 16'h2000}; vecs[3]  = '{4'b0110, 16'h1000};
      vecs[4]  = '{4'b1000, 16'h0800}; vecs[5]  = '{4'b1010, 16'h0400};
      vecs[6]  = '{4'b1100, 16'h0200}; vecs[7]  = '{4'b1110, 16'h0100};
      vecs[8]  = '{4'b1111, 16'h0080}; vecs[9]  = '{4'b1101, 16'h0040};
      vecs[10] = '{4'b1011, 16'h0020}; vecs[11] = '{4'b1001, 16'h0010};
      vecs[12] = '{4'b0111, 16'h0008}; vecs[13] = '{4'b0101, 16'h0004};
      vecs[14] = '{4'b0011, 16'h0002}; vecs[15] = '{4'b0001, 16'h0001};

      rst = 1'b0; En = 1'b1; err_clr = 1'b0;
      bus.code_in = '0; bus.code_valid = 1'b0; bus.grant_ack = 1'b0;
      err_m = 1'b0; grants_m = 0; timeouts_m = 0;
      #2 rst = 1'b1;
      #2;
      check("rst_grant", 32'(bus.grant), 32'd0);
      check("rst_valid", 32'(bus.grant_valid), 32'd0);
      check("rst_code", 32'(bus.grant_code), 32'd0);
      check("rst_err", 32'(timeout_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check_stats();
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      tick();

      // Full code sweep with immediate ack.
      for (int i = 0; i < 16; i++)
         run_txn(vecs[i].code, vecs[i].exp_grant, 0, 1'b0, -1);

      // Timeout on code 0110, then clear the sticky error.
      run_txn(4'b0110, 16'h1000, 10, 1'b0, -1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      err_m = 1'b0; grants_m = 0; timeouts_m = 0;
      check("err_cleared", 32'(timeout_err), 32'd0);

      // Ack on the expiry cycle wins; then err_clr on the expiry cycle loses to the set.
      run_txn(4'b1100, 16'h0200, T - 1, 1'b0, -1);
      check("ack_at_expiry_err", 32'(timeout_err), 32'd0);
      run_txn(4'b0101, 16'h0004, 10, 1'b0, T - 1);
      check("clr_vs_set_err", 32'(timeout_err), 32'd1);

      // Reset mid-GRANT with a held valid code.
      bus.code_in = 4'b0000; bus.code_valid = 1'b1;
      tick();
      bus.code_in = 4'b0011;
      check("pre_rst_grant", 32'(bus.grant), 32'h8000);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_grant", 32'(bus.grant), 32'd0);
      check("mid_rst_valid", 32'(bus.grant_valid), 32'd0);
      check("mid_rst_code", 32'(bus.grant_code), 32'd0);
      check("mid_rst_err", 32'(timeout_err), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      err_m = 1'b0; grants_m = 0; timeouts_m = 0;
      check_stats();
      @(negedge clk) rst = 1'b0;
      tick();
      bus.code_valid = 1'b0;
      check("post_rst_grant", 32'(bus.grant), 32'h0002);
      check("post_rst_valid", 32'(bus.grant_valid), 32'd1);
      bus.grant_ack = 1'b1;
      tick();
      bus.grant_ack = 1'b0;
      grants_m = 1;
      check("post_rst_release", 32'(bus.grant), 32'd0);
      check_stats();

      // En dropped during GRANT, then a held code refused while disabled.
      bus.code_in = 4'b1010; bus.code_valid = 1'b1;
      tick();
      bus.code_valid = 1'b0;
      grants_m++;
      check("en_grant", 32'(bus.grant), 32'h0400);
      En = 1'b0;
      tick();
      check("en_drop_grant", 32'(bus.grant), 32'd0);
      check("en_drop_valid", 32'(bus.grant_valid), 32'd0);
      check("en_drop_err", 32'(timeout_err), 32'd0);
      bus.code_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 check("en0_ready", 32'(bus.code_ready), 32'd0);
         tick();
         check("en0_no_grant", 32'(bus.grant_valid), 32'd0);
         check("en0_busy", 32'(busy), 32'd0);
      end
      bus.code_valid = 1'b0;
      En = 1'b1;
      check_stats();

`ifdef DEC_STATS_EN
      // Counters: 3 acked grants plus one timeout, then err_clr clears both.
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      err_m = 1'b0; grants_m = 0; timeouts_m = 0;
      for (int i = 0; i < 3; i++) run_txn(vecs[i].code, vecs[i].exp_grant, 0, 1'b0, -1);
      run_txn(4'b1111, 16'h0080, 10, 1'b0, -1);
      check("stats_grants_4", 32'(stat_grants), 32'd4);
      check("stats_timeouts_1", 32'(stat_timeouts), 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      err_m = 1'b0; grants_m = 0; timeouts_m = 0;
      check("stats_grants_clr", 32'(stat_grants), 32'd0);
      check("stats_timeouts_clr", 32'(stat_timeouts), 32'd0);
`endif

      // Randomized transactions against the duration model.
      for (int n = 0; n < 60; n++) begin
         logic [3:0] c;
         c = 4'($urandom_range(0, 15));
         run_txn(c, ref_grant(c), int'($urandom_range(0, 6)),
                 ($urandom_range(0, 7) == 0), int'($urandom_range(0, 9)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
